// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor fetch-redirect controller.
package bp_pkg;

    localparam int unsigned     PC_W   = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } bp_entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } bp_state_t;

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of fetched-instruction predictions, with synchronous clear.
module pred_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  bp_entry_t wdata_i,
    output logic      full_o,
    output logic      empty_o,
    output bp_entry_t head_o
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    bp_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem[wr_q] <= wdata_i;
    end

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem[rd_q];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Picks the next fetch PC, tracks in-flight predictions, and on resolve
// redirects/flushes the front end and trains the predictor.
module branch_pred_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter logic [31:0] PC_INC = 32'd4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      f_pc,
    input  logic             f_predict_valid,
    input  logic [31:0]      f_predict_addr,
    input  logic             f_fire,
    input  logic             x_valid,
    input  logic             x_is_branch,
    input  logic             x_taken,
    input  logic [31:0]      x_target,
    output logic [31:0]      f_next_pc,
    output logic             f_stall,
    output logic             flush,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             err
);
    import bp_pkg::*;

    bp_state_t        state_q, state_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
    logic             upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             q_full, q_empty, push_en, pop_en, push_req, in_redir, mispredict;
    bp_entry_t        head, wentry;
    logic [31:0]      seq_pc, actual_next, pred_next;

    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (mispredict),
        .push_i  (push_en),
        .pop_i   (pop_en),
        .wdata_i (wentry),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (head)
    );

    always_comb begin
        in_redir    = (state_q == REDIRECT);
        pop_en      = x_valid & ~q_empty & ~in_redir;
        push_req    = f_fire & ~in_redir;
        seq_pc      = head.pc + PC_INC;
        actual_next = (x_is_branch && x_taken) ? x_target : seq_pc;
        pred_next   = head.pred_taken ? head.pred_target : seq_pc;
        // A predicted-taken non-branch is an alias even if its target happens to be sequential.
        mispredict  = pop_en & ((actual_next != pred_next) | (~x_is_branch & head.pred_taken));
        push_en     = push_req & (~q_full | pop_en) & ~mispredict;

        wentry.pc          = f_pc;
        wentry.pred_taken  = f_predict_valid;
        wentry.pred_target = f_predict_addr;

        state_d       = mispredict ? REDIRECT : RUN;
        redirect_pc_d = mispredict ? actual_next : redirect_pc_q;
        cnt_d         = (mispredict && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        err_d         = err_q | (push_req & q_full & ~pop_en) | (x_valid & q_empty & ~in_redir);

        upd_valid_d  = pop_en & (x_is_branch | mispredict);
        upd_pc_d     = upd_pc_q;
        upd_taken_d  = upd_taken_q;
        upd_target_d = upd_target_q;
        if (upd_valid_d) begin
            upd_pc_d     = head.pc;
            upd_taken_d  = x_is_branch & x_taken;
            upd_target_d = x_is_branch ? x_target : seq_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_target_q  <= upd_target_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
        end
    end

    assign f_next_pc      = in_redir ? redirect_pc_q
                          : (f_predict_valid ? f_predict_addr : f_pc + PC_INC);
    assign f_stall        = q_full & ~in_redir;
    assign flush          = in_redir;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_taken      = upd_taken_q;
    assign upd_target     = upd_target_q;
    assign mispredict_cnt = cnt_q;
    assign err            = err_q;

endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Fetch-redirect and training controller for the `branch_predictor`. It picks the next fetch PC from the predictor output and keeps every fetched instruction's prediction in an in-order queue until execute. When execute resolves the instruction, the block checks the prediction, redirects and flushes the front end on a mispredict, and drives the predictor's training port. It sits between the fetch PC register, the predictor, and the execute-stage branch unit.

## Interface
Parameters:
- `DEPTH`, 4: in-flight prediction queue entries, power of two, at least F-to-X distance + 1.
- `PC_INC`, 4: sequential PC increment.
- `CNT_W`, 16: mispredict counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `f_pc`  in  32  PC currently in fetch.
- `f_predict_valid`  in  1  predictor says taken for `f_pc`.
- `f_predict_addr`  in  32  predicted target for `f_pc`.
- `f_fire`  in  1  fetch instruction accepted into decode this cycle.
- `x_valid`  in  1  a real (non-bubble) instruction completes execute this cycle.
- `x_is_branch`  in  1  that instruction is a branch or jump.
- `x_taken`  in  1  actual direction.
- `x_target`  in  32  actual taken target.
- `f_next_pc`  out  32  PC to load into the fetch register.
- `f_stall`  out  1  queue full; fetch must hold.
- `flush`  out  1  kill all instructions in F, D and X.
- `upd_valid`  out  1  predictor training strobe (maps to `x_predict_res` semantics).
- `upd_pc`  out  32  trained PC.
- `upd_taken`  out  1  trained direction.
- `upd_target`  out  32  trained target.
- `mispredict_cnt`  out  CNT_W  saturating mispredict count.
- `err`  out  1  sticky protocol error.

## Operation
- Queue entry: {pc, pred_taken, pred_target}. Push on `f_fire` (if not full), pop on `x_valid` (if not empty). Push and pop in the same cycle are legal, including when the queue is full. Occupancy is then unchanged.
- FSM states:
  - RUN (reset state).
  - REDIRECT: lasts one cycle, then returns to RUN.
- Check at pop, with head entry h:
  - If `x_is_branch`, actual_next = `x_taken` ? `x_target` : h.pc+PC_INC. Otherwise actual_next = h.pc+PC_INC.
  - pred_next = h.pred_taken ? h.pred_target : h.pc+PC_INC.
  - Mismatch causes a mispredict. A non-branch predicted taken (alias) counts as a mispredict.
- On mispredict in RUN:
  - Latch redirect_pc = actual_next.
  - Go to REDIRECT.
  - Clear the queue at the clock edge. Any same-cycle push is discarded.
  - Increment `mispredict_cnt`, saturating at all-ones.
- `f_next_pc`:
  - In REDIRECT: redirect_pc.
  - Otherwise: `f_predict_valid` ? `f_predict_addr` : `f_pc`+PC_INC.
  - Arithmetic is 32-bit modulo, so 0xFFFFFFFC+4 = 0.
- In REDIRECT:
  - `flush`=1.
  - `f_fire` and `x_valid` are ignored: those instructions are being killed.
- Training:
  - Every popped branch produces one `upd_valid` pulse with {h.pc, `x_taken`, `x_target`}.
  - A mispredicted non-branch produces an update with taken=0 and target=h.pc+PC_INC to untrain the alias.
  - Correct non-branches produce no update.
- `f_stall` = queue full and not REDIRECT. A `f_fire` while full with no pop is dropped and sets `err`.
- `x_valid` with the queue empty (outside REDIRECT) is ignored and sets `err`.
- `err` clears only on reset.

## Timing
- Reset values: state RUN, queue empty, `flush`=0, `f_stall`=0, `upd_valid`=0, `upd_pc`/`upd_target`=0, `upd_taken`=0, `mispredict_cnt`=0, `err`=0. `f_next_pc` is combinational from inputs after reset.
- `f_next_pc` and `f_stall` are combinational, with zero latency.
- Pop in cycle N produces the following in cycle N+1, all registered:
  - `upd_*`;
  - `flush`;
  - redirect `f_next_pc`.
- The fetch register loads the redirect at the end of N+1. The first correct-path `f_fire` can occur in N+2.
- Mispredict-to-correct-fetch penalty is 2 cycles plus pipeline depth.
- Async reset during REDIRECT aborts the redirect: no `flush` after reset release.

## Structure
- `bp_pkg` holds:
  - `PC_W`=32 and `PC_INC`;
  - the queue entry struct;
  - the FSM state enum {RUN, REDIRECT}.
- Sub-module `pred_queue`: parameterised sync FIFO with push, pop, full, empty, head, and synchronous clear. It uses `clk`/`rst_n`.
- The top level holds the FSM, compare, counter and update registers.

## Test plan
- Reset then steady stream, with `f_pc`=0x100, no predictions, pushes and pops balanced, non-branches.
  - `f_next_pc`=0x104.
  - No `flush`, no `upd_valid`, `mispredict_cnt`=0.
- Correct taken prediction: push {0x200, taken, 0x400}, pop with `x_is_branch`=1, `x_taken`=1, `x_target`=0x400.
  - Next cycle `upd_valid`=1, `upd_pc`=0x200, `upd_taken`=1.
  - `flush`=0.
- Not-taken mispredict: push {0x300, taken, 0x500}, resolve not taken.
  - Next cycle `flush`=1 and `f_next_pc`=0x304.
  - Queue empty, `mispredict_cnt`=1.
- Alias: a non-branch at 0x600 predicted taken to 0x800.
  - `flush`, redirect to 0x604.
  - `upd_taken`=0, `upd_target`=0x604.
- Fill DEPTH=4 with no pops: `f_stall`=1.
  - Push and pop together keep `f_stall`=1.
  - Extra `f_fire` sets `err`.
- Counter saturation: with CNT_W=2, 5 mispredicts give `mispredict_cnt`=3.
- Reset mid-REDIRECT: assert `rst_n`=0 in the flush cycle, then release.
  - `flush`=0 and the queue is empty.
